ysyx_25030093_mem_arbiter: RTL and testbench

Two-master, one-slave memory arbiter that shares the core's single memory port between instruction fetch (IFU, master 0) and load/store (LSU, master 1). It sits between the fetch/LSU stages and the memory/DPI bridge. It serialises transactions with a four-state FSM and latches the granted request. It returns each response only to the master that issued it, and turns a hung memory into an error response via a timeout counter.

---
 rtl/ysyx_25030093_mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_ysyx_25030093_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25030093_mem_arbiter.sv
// Two-master (IFU=0, LSU=1) to one-slave memory arbiter with a request timeout.
// Optional YSYX_25030093_ARB_RR_EN selects round-robin; otherwise the LSU wins ties.
module ysyx_25030093_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rsp_valid,
  input  logic        ifu_rsp_ready,
  output logic [31:0] ifu_rdata,
  output logic        ifu_rsp_err,

  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_rsp_valid,
  input  logic        lsu_rsp_ready,
  output logic [31:0] lsu_rdata,
  output logic        lsu_rsp_err,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  output logic        mem_rsp_ready,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic GNT_IFU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e           state;
  logic             grant_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rdata_q;
  logic             err_q;

  logic gnt_ifu_c;
  logic gnt_lsu_c;
  logic timeout_c;
  logic rsp_done_c;

`ifdef YSYX_25030093_ARB_RR_EN
  logic last_lsu_q;
`endif

  // Grant at most one master per cycle, only while idle and out of reset
  always_comb begin
    gnt_ifu_c = 1'b0;
    gnt_lsu_c = 1'b0;
    if (!rst && state == IDLE) begin
`ifdef YSYX_25030093_ARB_RR_EN
      if (ifu_req_valid && lsu_req_valid) begin
        gnt_lsu_c = ~last_lsu_q;
        gnt_ifu_c = last_lsu_q;
      end else begin
        gnt_ifu_c = ifu_req_valid;
        gnt_lsu_c = lsu_req_valid;
      end
`else
      gnt_lsu_c = lsu_req_valid;
      gnt_ifu_c = ifu_req_valid & ~lsu_req_valid;
`endif
    end
  end

  assign ifu_req_ready = gnt_ifu_c;
  assign lsu_req_ready = gnt_lsu_c;
  assign timeout_c     = (cnt_q == CNT_LAST);
  assign rsp_done_c    = (grant_q == GNT_LSU) ? lsu_rsp_ready : ifu_rsp_ready;

  assign ifu_rdata   = rdata_q;
  assign ifu_rsp_err = err_q;
  assign lsu_rdata   = rdata_q;
  assign lsu_rsp_err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      grant_q       <= GNT_IFU;
      cnt_q         <= '0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_rsp_ready <= 1'b0;
      mem_addr      <= '0;
      mem_wen       <= 1'b0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
      ifu_rsp_valid <= 1'b0;
      lsu_rsp_valid <= 1'b0;
`ifdef YSYX_25030093_ARB_RR_EN
      last_lsu_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gnt_lsu_c) begin
            grant_q       <= GNT_LSU;
            mem_addr      <= lsu_addr;
            mem_wen       <= lsu_wen;
            mem_wdata     <= lsu_wdata;
            mem_wmask     <= lsu_wmask;
            cnt_q         <= '0;
            mem_req_valid <= 1'b1;
            state         <= REQ;
`ifdef YSYX_25030093_ARB_RR_EN
            last_lsu_q    <= 1'b1;
`endif
          end else if (gnt_ifu_c) begin
            grant_q       <= GNT_IFU;
            mem_addr      <= ifu_addr;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            cnt_q         <= '0;
            mem_req_valid <= 1'b1;
            state         <= REQ;
`ifdef YSYX_25030093_ARB_RR_EN
            last_lsu_q    <= 1'b0;
`endif
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            mem_rsp_ready <= 1'b1;
            cnt_q         <= cnt_q + 16'd1;
            state         <= WAIT;
          end else if (timeout_c) begin
            // Slave never accepted: abandon the request and report an error
            mem_req_valid <= 1'b0;
            rdata_q       <= '0;
            err_q         <= 1'b1;
            ifu_rsp_valid <= (grant_q == GNT_IFU);
            lsu_rsp_valid <= (grant_q == GNT_LSU);
            state         <= RESP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            mem_rsp_ready <= 1'b0;
            rdata_q       <= mem_rdata;
            err_q         <= 1'b0;
            ifu_rsp_valid <= (grant_q == GNT_IFU);
            lsu_rsp_valid <= (grant_q == GNT_LSU);
            state         <= RESP;
          end else if (timeout_c) begin
            mem_rsp_ready <= 1'b0;
            rdata_q       <= '0;
            err_q         <= 1'b1;
            ifu_rsp_valid <= (grant_q == GNT_IFU);
            lsu_rsp_valid <= (grant_q == GNT_LSU);
            state         <= RESP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RESP: begin
          if (rsp_done_c) begin
            ifu_rsp_valid <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25030093_mem_arbiter.sv
// Scoreboard bench for ysyx_25030093_mem_arbiter with a configurable slave model.
module tb_ysyx_25030093_mem_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_req_valid = 1'b0, ifu_rsp_ready = 1'b1;
  logic [31:0] ifu_addr = '0;
  logic        ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid = 1'b0, lsu_rsp_ready = 1'b1, lsu_wen = 1'b0;
  logic [31:0] lsu_addr = '0, lsu_wdata = '0;
  logic [3:0]  lsu_wmask = '0;
  logic        lsu_req_ready, lsu_rsp_valid, lsu_rsp_err;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid, mem_wen, mem_rsp_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Slave model configuration
  int          slv_req_wait = 0;
  logic        slv_mute     = 1'b0;
  logic [31:0] slv_data     = '0;
  int          req_cnt      = 0;

  typedef struct {
    logic        id;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];
  logic in_rsp = 1'b0;

  ysyx_25030093_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .ifu_rdata(ifu_rdata), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
    .lsu_rdata(lsu_rdata), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Slave: accepts after slv_req_wait cycles, responds in the first WAIT cycle unless muted
  always @(posedge clk) begin
    #1;
    if (mem_req_valid) begin
      mem_req_ready = (req_cnt >= slv_req_wait);
      req_cnt++;
    end else begin
      mem_req_ready = 1'b0;
      req_cnt = 0;
    end
    mem_rsp_valid = mem_rsp_ready && !slv_mute;
    mem_rdata = slv_data;
  end

  // Monitor: pushes expectations on accept, checks responses against the queue
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      in_rsp = 1'b0;
    end else begin
      if (ifu_rsp_valid || lsu_rsp_valid) begin
        check_eq("rsp_exclusive", 64'(ifu_rsp_valid && lsu_rsp_valid), 64'd0);
        check_eq("no_grant_in_resp", 64'(ifu_req_ready || lsu_req_ready), 64'd0);
        check_eq("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb[0];
          check_eq("rsp_id", 64'(lsu_rsp_valid), 64'(e.id));
          check_eq("rsp_rdata", 64'(lsu_rsp_valid ? lsu_rdata : ifu_rdata), 64'(e.rdata));
          check_eq("rsp_err", 64'(lsu_rsp_valid ? lsu_rsp_err : ifu_rsp_err), 64'(e.err));
          if (!in_rsp) check_eq("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
          in_rsp = 1'b1;
          if ((ifu_rsp_valid && ifu_rsp_ready) || (lsu_rsp_valid && lsu_rsp_ready)) begin
            void'(sb.pop_front());
            in_rsp = 1'b0;
          end
        end
      end
      if (ifu_req_valid && ifu_req_ready)
        sb.push_back('{1'b0, slv_mute ? 32'd0 : slv_data, slv_mute,
                       slv_mute ? TO + 1 : 3 + slv_req_wait, cyc});
      if (lsu_req_valid && lsu_req_ready)
        sb.push_back('{1'b1, slv_mute ? 32'd0 : slv_data, slv_mute,
                       slv_mute ? TO + 1 : 3 + slv_req_wait, cyc});
    end
  end

  task automatic ifu_issue(input logic [31:0] a);
    logic ok;
    ok = 1'b0;
    ifu_addr = a;
    ifu_req_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifu_req_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    check_eq("ifu_accept", 64'(ok), 64'd1);
  endtask

  task automatic lsu_issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] m);
    logic ok;
    ok = 1'b0;
    lsu_addr = a; lsu_wen = w; lsu_wdata = d; lsu_wmask = m;
    lsu_req_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (lsu_req_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    lsu_req_valid = 1'b0;
    check_eq("lsu_accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !in_rsp) break;
    end
    check_eq("drain", 64'(sb.size()), 64'd0);
    check_eq("idle_outputs", 64'({mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rst_vec;
    logic        ok;
    logic        exp_lsu;
    #1 rst = 1'b1;
    #3;
    rst_vec = {mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid,
               ifu_req_ready, lsu_req_ready, mem_wen, ifu_rsp_err, lsu_rsp_err};
    check_eq("reset_flags", rst_vec, 64'd0);
    check_eq("reset_mem_addr", 64'(mem_addr), 64'd0);
    check_eq("reset_mem_wdata", 64'({mem_wdata, mem_wmask}), 64'd0);
    check_eq("reset_rdata", 64'({ifu_rdata, lsu_rdata}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single IFU read, zero-wait slave
    slv_data = 32'h0010_0093; slv_req_wait = 0; slv_mute = 1'b0;
    ifu_issue(32'h8000_0000);
    wait_drain();

    // LSU write with the slave stalling mem_req_ready for 5 cycles
    slv_data = 32'h1234_5678; slv_req_wait = 5;
    lsu_issue(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("wr_req_held", 64'({mem_req_valid, mem_req_ready}), 64'b10);
      check_eq("wr_addr", 64'(mem_addr), 64'h8000_1000);
      check_eq("wr_data", 64'({mem_wen, mem_wdata, mem_wmask}), {27'd0, 1'b1, 32'hDEAD_BEEF, 4'hF});
    end
    wait_drain();
    slv_req_wait = 0;

    // Timeout in WAIT (IFU) and in REQ (LSU)
    slv_mute = 1'b1; slv_data = 32'hFFFF_FFFF;
    ifu_issue(32'h8000_0040);
    wait_drain();
    slv_req_wait = 100;
    lsu_issue(32'h8000_2000, 1'b0, 32'd0, 4'h0);
    wait_drain();
    slv_req_wait = 0; slv_mute = 1'b0;

    // IFU response backpressure with a pending LSU request
    slv_data = 32'h0000_0013;
    ifu_rsp_ready = 1'b0;
    ifu_issue(32'h8000_0080);
    fork
      lsu_issue(32'h8000_3000, 1'b0, 32'd0, 4'h0);
      begin
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (ifu_rsp_valid) begin ok = 1'b1; break; end
        end
        check_eq("bp_rsp_seen", 64'(ok), 64'd1);
        repeat (3) @(posedge clk);
        #1 ifu_rsp_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset pulsed while waiting for a response
    slv_mute = 1'b1;
    ifu_issue(32'h8000_00C0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_rsp_ready) begin ok = 1'b1; break; end
    end
    check_eq("mid_wait_reached", 64'(ok), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async_flags", 64'({mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
    check_eq("rst_async_addr", 64'(mem_addr), 64'd0);
    check_eq("rst_async_rsp", 64'({ifu_rdata, ifu_rsp_err}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    slv_mute = 1'b0; slv_data = 32'hCAFE_0001;
    ifu_issue(32'h8000_0100);
    wait_drain();

    // Simultaneous requests from a fresh reset
    pulse_reset();
    slv_data = 32'h0000_0A0A;
    for (int r = 0; r < 4; r++) begin
`ifdef YSYX_25030093_ARB_RR_EN
      exp_lsu = (r % 2 == 0);
`else
      exp_lsu = 1'b1;
`endif
      ifu_addr = 32'h8000_0200 + 32'(r * 4);
      lsu_addr = 32'h8000_4000 + 32'(r * 4);
      lsu_wen = 1'b0; lsu_wmask = 4'h0;
      ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (ifu_req_ready || lsu_req_ready) begin ok = 1'b1; break; end
      end
      check_eq("tie_seen", 64'(ok), 64'd1);
      check_eq("tie_single", 64'(ifu_req_ready && lsu_req_ready), 64'd0);
      check_eq("tie_winner_lsu", 64'(lsu_req_ready), 64'(exp_lsu));
      @(posedge clk); #1;
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      wait_drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
